// File: rtl/path_swap_seq.sv
// path_swap_seq: DEPTH x WIDTH element store with a sequenced two-element swap.
// A swap reads both elements, then writes each into the other's slot.
// Each step takes one cycle. Elements can also be loaded directly while idle.
// The store can be read at any time, with one cycle of latency.
//
// Ports:
//   system1000      - clock (rising edge)
//   system1000_rst  - synchronous active-high reset
//   swap_valid_i    - swap request valid
//   swap_ready_o    - swap request can be accepted (combinational)
//   idx_a_i/idx_b_i - element indices to exchange
//   wr_en_i         - direct load strobe (honoured only while idle)
//   wr_idx_i        - load index
//   wr_data_i       - load data
//   rd_idx_i        - lookup index
//   rd_data_o       - registered lookup data
//   done_o          - one-cycle pulse when a swap completes
//   err_o           - one-cycle pulse on a range error
//
// Optional feature macro: PATH_SWAP_BOUNDS_CHECK_EN enables index range checking.
// When it is undefined, err_o is tied to 0.
module path_swap_seq #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 1000,
    parameter int unsigned IDX_W = 16
) (
    input  logic             system1000,
    input  logic             system1000_rst,
    input  logic             swap_valid_i,
    output logic             swap_ready_o,
    input  logic [IDX_W-1:0] idx_a_i,
    input  logic [IDX_W-1:0] idx_b_i,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             done_o,
    output logic             err_o
);

    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR_A, WR_B} state_t;

    logic [WIDTH-1:0]  mem [DEPTH];
    state_t            state, state_n;
    logic [ADDR_W-1:0] a_q, b_q;
    logic [WIDTH-1:0]  cap_a, cap_b;
    logic              accept_c, load_c;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              done_n, err_n;
    logic              swap_oob_c, wr_oob_c, rd_oob_c;

`ifdef PATH_SWAP_BOUNDS_CHECK_EN
    // One extra bit so a DEPTH equal to 2**IDX_W still compares correctly.
    localparam int unsigned LIM_W = IDX_W + 1;
    localparam logic [LIM_W-1:0] DEPTH_LIM = LIM_W'(DEPTH);

    function automatic logic is_oob(input logic [IDX_W-1:0] idx);
        return {1'b0, idx} >= DEPTH_LIM;
    endfunction

    assign swap_oob_c = is_oob(idx_a_i) | is_oob(idx_b_i);
    assign wr_oob_c   = is_oob(wr_idx_i);
    assign rd_oob_c   = is_oob(rd_idx_i);
`else
    assign swap_oob_c = 1'b0;
    assign wr_oob_c   = 1'b0;
    assign rd_oob_c   = 1'b0;

    // Index bits above the array address are meaningless without range checking.
    if (IDX_W > ADDR_W) begin : g_unused
        logic unused_idx_bits;
        assign unused_idx_bits = ^{wr_idx_i[IDX_W-1:ADDR_W], rd_idx_i[IDX_W-1:ADDR_W]};
    end
`endif

    // A load takes priority over a swap request in the same cycle.
    assign swap_ready_o = (state == IDLE) & ~wr_en_i & ~system1000_rst;
    assign accept_c     = swap_valid_i & swap_ready_o;
    assign load_c       = wr_en_i & (state == IDLE) & ~system1000_rst;

    // Next-state logic, plus the store write port and completion pulses.
    always_comb begin
        state_n   = state;
        mem_we    = 1'b0;
        mem_waddr = ADDR_W'(wr_idx_i);
        mem_wdata = wr_data_i;
        done_n    = 1'b0;
        err_n     = 1'b0;
        case (state)
            IDLE: begin
                if (load_c) begin
                    if (wr_oob_c) err_n  = 1'b1;
                    else          mem_we = 1'b1;
                end else if (accept_c) begin
                    if (swap_oob_c) begin
                        done_n = 1'b1;
                        err_n  = 1'b1;
                    end else if (idx_a_i == idx_b_i) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = RD_A;
                    end
                end
            end
            RD_A: state_n = RD_B;
            RD_B: state_n = WR_A;
            WR_A: begin
                mem_we    = 1'b1;
                mem_waddr = a_q;
                mem_wdata = cap_b;
                state_n   = WR_B;
            end
            WR_B: begin
                mem_we    = 1'b1;
                mem_waddr = b_q;
                mem_wdata = cap_a;
                done_n    = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Reset aborts an in-flight swap; any write already committed stays.
        if (system1000_rst) mem_we = 1'b0;
    end

    // Storage array; its contents are never reset.
    always_ff @(posedge system1000) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Latched swap indices and the captured element values.
    always_ff @(posedge system1000) begin
        if (accept_c) begin
            a_q <= ADDR_W'(idx_a_i);
            b_q <= ADDR_W'(idx_b_i);
        end
        if (state == RD_A) cap_a <= mem[a_q];
        if (state == RD_B) cap_b <= mem[b_q];
    end

    // State register and registered outputs.
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            state     <= IDLE;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            rd_data_o <= '0;
        end else begin
            state     <= state_n;
            done_o    <= done_n;
            err_o     <= err_n;
            rd_data_o <= rd_oob_c ? '0 : mem[ADDR_W'(rd_idx_i)];
        end
    end

endmodule

// File: tb/tb_path_swap_seq.sv
// Testbench for path_swap_seq: directed scenarios followed by randomized swaps.
// Results are compared against an array model of the element store.
module tb_path_swap_seq;

    localparam int unsigned WIDTH = 65;
    localparam int unsigned DEPTH = 1000;
    localparam int unsigned IDX_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             swap_valid;
    logic             swap_ready;
    logic [IDX_W-1:0] idx_a, idx_b;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [WIDTH-1:0] wr_data;
    logic [IDX_W-1:0] rd_idx;
    logic [WIDTH-1:0] rd_data;
    logic             done;
    logic             err;

    int errs   = 0;
    int checks = 0;

    logic [WIDTH-1:0] model_mem [DEPTH];

    always #5 clk = ~clk;

    path_swap_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .swap_valid_i   (swap_valid),
        .swap_ready_o   (swap_ready),
        .idx_a_i        (idx_a),
        .idx_b_i        (idx_b),
        .wr_en_i        (wr_en),
        .wr_idx_i       (wr_idx),
        .wr_data_i      (wr_data),
        .rd_idx_i       (rd_idx),
        .rd_data_o      (rd_data),
        .done_o         (done),
        .err_o          (err)
    );

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; the bench drives and samples at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [WIDTH-1:0] rnd_data();
        return {1'($urandom), $urandom(), $urandom()};
    endfunction

    task automatic load(input int idx, input logic [WIDTH-1:0] d);
        wr_en   = 1'b1;
        wr_idx  = IDX_W'(idx);
        wr_data = d;
        #1 chk("load_ready_low", {64'd0, swap_ready}, '0);
        step();
        wr_en = 1'b0;
        model_mem[idx] = d;
    endtask

    task automatic read_chk(input int idx, input string tag);
        rd_idx = IDX_W'(idx);
        step();
        chk(tag, rd_data, model_mem[idx]);
    endtask

    // Issue one swap and check done/ready timing cycle by cycle.
    task automatic swap(input int a, input int b, input string tag);
        logic [WIDTH-1:0] tmp;
        swap_valid = 1'b1;
        idx_a = IDX_W'(a);
        idx_b = IDX_W'(b);
        #1 chk({tag, "_ready"}, {64'd0, swap_ready}, 65'd1);
        step();
        swap_valid = 1'b0;
        idx_a = IDX_W'($urandom());
        idx_b = IDX_W'($urandom());
        if (a == b) begin
            chk({tag, "_done_c1"}, {64'd0, done}, 65'd1);
            chk({tag, "_idle_c1"}, {64'd0, swap_ready}, 65'd1);
            chk({tag, "_err"}, {64'd0, err}, '0);
            step();
            chk({tag, "_done_c2"}, {64'd0, done}, '0);
        end else begin
            for (int c = 1; c <= 4; c++) begin
                chk({tag, "_done_busy"}, {64'd0, done}, '0);
                chk({tag, "_ready_busy"}, {64'd0, swap_ready}, '0);
                step();
            end
            chk({tag, "_done_c5"}, {64'd0, done}, 65'd1);
            chk({tag, "_ready_c5"}, {64'd0, swap_ready}, 65'd1);
            chk({tag, "_err"}, {64'd0, err}, '0);
        end
        tmp = model_mem[a];
        model_mem[a] = model_mem[b];
        model_mem[b] = tmp;
    endtask

    initial begin
        logic [WIDTH-1:0] va, vb, vc, vx, vy, big;
        int pool [8];

        rst = 1'b1; swap_valid = 1'b1; idx_a = '0; idx_b = 16'd1;
        wr_en = 1'b0; wr_idx = '0; wr_data = '0; rd_idx = '0;
        step();
        step();
        #1;
        chk("rst_ready", {64'd0, swap_ready}, '0);
        chk("rst_done", {64'd0, done}, '0);
        chk("rst_err", {64'd0, err}, '0);
        chk("rst_rd_data", rd_data, '0);
        swap_valid = 1'b0;
        rst = 1'b0;
        #1 chk("post_rst_ready", {64'd0, swap_ready}, 65'd1);
        step();

        // Far-apart swap with a 65-bit value.
        big = 65'h1_0000_0000_0000_0003;
        load(3, big);
        load(997, 65'h5);
        swap(3, 997, "swap3_997");
        read_chk(3, "rd3_model");
        chk("rd3_const", rd_data, 65'h5);
        read_chk(997, "rd997_model");
        chk("rd997_const", rd_data, big);

        // Swap an element with itself.
        load(42, 65'hAB);
        swap(42, 42, "swap42");
        read_chk(42, "rd42_model");
        chk("rd42_const", rd_data, 65'hAB);

        // Back-to-back swaps with valid held high.
        va = rnd_data(); vb = rnd_data(); vc = rnd_data();
        load(0, va); load(1, vb); load(2, vc);
        swap_valid = 1'b1; idx_a = 16'd0; idx_b = 16'd1;
        step();
        idx_a = 16'd1; idx_b = 16'd2;
        for (int c = 1; c <= 4; c++) begin
            chk("b2b_done_busy1", {64'd0, done}, '0);
            chk("b2b_ready_busy1", {64'd0, swap_ready}, '0);
            step();
        end
        chk("b2b_done_c5", {64'd0, done}, 65'd1);
        chk("b2b_ready_c5", {64'd0, swap_ready}, 65'd1);
        step();
        swap_valid = 1'b0;
        for (int c = 6; c <= 9; c++) begin
            chk("b2b_done_busy2", {64'd0, done}, '0);
            step();
        end
        chk("b2b_done_c10", {64'd0, done}, 65'd1);
        model_mem[0] = vb; model_mem[1] = vc; model_mem[2] = va;
        read_chk(0, "b2b_rd0");
        chk("b2b_rd0_const", rd_data, vb);
        read_chk(1, "b2b_rd1");
        chk("b2b_rd1_const", rd_data, vc);
        read_chk(2, "b2b_rd2");
        chk("b2b_rd2_const", rd_data, va);

        // Reset during the final write step leaves a half-completed swap.
        vx = rnd_data(); vy = rnd_data();
        load(10, vx); load(20, vy);
        swap_valid = 1'b1; idx_a = 16'd10; idx_b = 16'd20;
        step();
        swap_valid = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        chk("abort_no_done", {64'd0, done}, '0);
        chk("abort_rd_zero", rd_data, '0);
        chk("abort_ready_low", {64'd0, swap_ready}, '0);
        step();
        rst = 1'b0;
        #1 chk("abort_ready_after", {64'd0, swap_ready}, 65'd1);
        step();
        chk("abort_no_done2", {64'd0, done}, '0);
        model_mem[10] = vy;
        read_chk(10, "abort_rd10");
        chk("abort_rd10_const", rd_data, vy);
        read_chk(20, "abort_rd20");
        chk("abort_rd20_const", rd_data, vy);

        // A load and a swap request in the same cycle: the load wins, the swap waits.
        load(51, rnd_data());
        va = rnd_data();
        wr_en = 1'b1; wr_idx = 16'd50; wr_data = va;
        swap_valid = 1'b1; idx_a = 16'd50; idx_b = 16'd51;
        #1 chk("coll_ready_low", {64'd0, swap_ready}, '0);
        step();
        wr_en = 1'b0;
        model_mem[50] = va;
        swap(50, 51, "coll_swap");
        read_chk(50, "coll_rd50");
        read_chk(51, "coll_rd51");
        chk("coll_rd51_const", rd_data, va);

        // Randomized swaps over a small pool of loaded elements.
        for (int i = 0; i < 8; i++) begin
            pool[i] = int'($urandom_range(100, DEPTH - 1));
            load(pool[i], rnd_data());
        end
        for (int i = 0; i < 24; i++) begin
            int ia, ib;
            ia = pool[$urandom_range(0, 7)];
            ib = (i % 6 == 0) ? ia : pool[$urandom_range(0, 7)];
            swap(ia, ib, "rnd_swap");
            read_chk(pool[$urandom_range(0, 7)], "rnd_rd");
        end
        for (int i = 0; i < 8; i++) read_chk(pool[i], "rnd_final");

`ifdef PATH_SWAP_BOUNDS_CHECK_EN
        // Out-of-range swap, read and load.
        vc = rnd_data();
        load(5, vc);
        swap_valid = 1'b1; idx_a = 16'd5; idx_b = 16'd1000;
        step();
        swap_valid = 1'b0;
        chk("oob_swap_done", {64'd0, done}, 65'd1);
        chk("oob_swap_err", {64'd0, err}, 65'd1);
        chk("oob_swap_idle", {64'd0, swap_ready}, 65'd1);
        step();
        chk("oob_swap_err_pulse", {64'd0, err}, '0);
        read_chk(5, "oob_rd5");
        chk("oob_rd5_const", rd_data, vc);
        rd_idx = 16'd1000;
        step();
        chk("oob_rd_zero", rd_data, '0);
        wr_en = 1'b1; wr_idx = 16'd1000; wr_data = rnd_data();
        step();
        wr_en = 1'b0;
        chk("oob_load_err", {64'd0, err}, 65'd1);
        step();
        chk("oob_load_err_pulse", {64'd0, err}, '0);
`else
        chk("err_tied_low", {64'd0, err}, '0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/path_swap_seq.md
PATH_SWAP_SEQ -- requirements
Module: path_swap_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 65, meaning bits per path element.
REQ-002 The block SHALL have parameter DEPTH, default 1000, meaning number of path elements.
REQ-003 The block SHALL have parameter IDX_W, default 16, meaning index port width (unsigned).
REQ-004 The block SHALL have port system1000, input, 1, the single clock; all logic SHALL be clocked on its rising edge.
REQ-005 The block SHALL have port system1000_rst, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port swap_valid_i, input, 1, meaning swap request valid.
REQ-007 The block SHALL have port swap_ready_o, output, 1, meaning swap request can be accepted.
REQ-008 The block SHALL have ports idx_a_i and idx_b_i, input, IDX_W each, meaning the two element indices to exchange.
REQ-009 The block SHALL have port wr_en_i, input, 1, meaning direct element write (load) strobe.
REQ-010 The block SHALL have ports wr_idx_i (input, IDX_W) and wr_data_i (input, WIDTH), carrying the load address and data.
REQ-011 The block SHALL have port rd_idx_i, input, IDX_W, meaning lookup address.
REQ-012 The block SHALL have port rd_data_o, output, WIDTH, meaning registered lookup data.
REQ-013 The block SHALL have port done_o, output, 1, a one-cycle pulse marking swap completion.
REQ-014 The block SHALL have port err_o, output, 1, a one-cycle pulse marking a range error.

Function
REQ-015 Storage SHALL be DEPTH x WIDTH, with no reset of its contents.
REQ-016 The FSM SHALL have states IDLE, RD_A, RD_B, WR_A, WR_B.
REQ-017 swap_ready_o SHALL equal (state==IDLE) & ~wr_en_i & ~system1000_rst.
REQ-018 A swap SHALL be accepted at the edge where swap_valid_i & swap_ready_o; idx_a_i and idx_b_i SHALL be latched at that edge.
REQ-019 If the latched indices differ, the state SHALL step through RD_A (capture mem[a]), RD_B (capture mem[b]), WR_A (mem[a] <= captured b), WR_B (mem[b] <= captured a), then IDLE, one state per cycle.
REQ-020 With the accept edge ending cycle 0, states SHALL occupy cycles 1-4, and done_o=1 with state IDLE in cycle 5; a new swap SHALL be acceptable in cycle 5.
REQ-021 If idx_a == idx_b, the state SHALL remain IDLE, memory SHALL be unchanged, and done_o=1 in cycle 1.
REQ-022 A load (wr_en_i=1 while state==IDLE) SHALL write wr_data_i to mem[wr_idx_i] at that edge, and a simultaneous swap SHALL NOT be accepted.
REQ-023 wr_en_i while state!=IDLE SHALL be ignored.
REQ-024 rd_data_o SHALL equal mem[rd_idx_i] as sampled at the previous edge (1-cycle latency); mid-swap reads MAY return the intermediate contents of cycles 3-4.
REQ-025 swap_valid_i while busy SHALL be held by the requester (valid/ready rule); request fields SHALL NOT be sampled outside the accept edge.

Reset
REQ-026 While system1000_rst=1: state=IDLE, swap_ready_o=0, done_o=0, err_o=0, rd_data_o=0.
REQ-027 Reset asserted mid-swap SHALL abort the swap with no done_o; a completed WR_A write SHALL persist (partial swap allowed).
REQ-028 swap_ready_o=1 SHALL hold in the first cycle after reset deasserts.

Configuration
REQ-029 Macro PATH_SWAP_BOUNDS_CHECK_EN defined: any accepted swap with an index >= DEPTH SHALL leave memory unchanged and pulse done_o=1 and err_o=1 in cycle 1.
REQ-030 With PATH_SWAP_BOUNDS_CHECK_EN defined, a load with wr_idx_i >= DEPTH SHALL be dropped and SHALL pulse err_o next cycle.
REQ-031 With PATH_SWAP_BOUNDS_CHECK_EN defined, rd_idx_i >= DEPTH SHALL return rd_data_o=0.
REQ-032 Macro undefined: no range logic; err_o SHALL be constant 0; out-of-range index behaviour is unspecified and SHALL NOT be driven.

Verification
REQ-033 Load mem[3]=0x1_0000_0000_0000_0003 and mem[997]=0x5; swap a=3, b=997 -> done_o in cycle 5; reads give mem[3]=0x5 and mem[997]=0x1_0000_0000_0000_0003.
REQ-034 Swap a=b=42 with mem[42]=0xAB -> done_o in cycle 1; mem[42]=0xAB; no state change.
REQ-035 Back-to-back swaps (0,1) then (1,2), valid held high, with mem[0..2]=A,B,C -> second accept in cycle 5, done_o in cycles 5 and 10, final mem[0..2]=B,C,A.
REQ-036 Assert reset in cycle 4 (WR_B) of swap (10,20) with mem[10]=X, mem[20]=Y -> no done_o; mem[10]=Y, mem[20]=Y; swap_ready_o=1 the cycle after reset release.
REQ-037 wr_en_i and swap_valid_i both high in IDLE -> write performed, swap_ready_o=0 that cycle; swap accepted next cycle.
REQ-038 With PATH_SWAP_BOUNDS_CHECK_EN: swap a=5, b=1000 -> done_o=1 and err_o=1 in cycle 1, memory unchanged; rd_idx_i=1000 -> rd_data_o=0.
